apb_slave_ctrl: RTL and testbench
=================================

APB_SLAVE_CTRL -- requirements
Module: apb_slave_ctrl

Interface
REQ-001 SHALL have one clock and synchronous, active-low reset: pclk (rising edge) and rst_n.
REQ-002 SHALL have these ports:
- pclk  in  1  APB clock.
- rst_n  in  1  sync active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1=write, 0=read.
- paddr  in  8  APB byte address.
- pwdata  in  8  APB write data.
- prdata  out  8  APB read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- mem_addr  out  4  memory address.
- mem_wen  out  1  memory write strobe.
- mem_ren  out  1  memory read strobe.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data, registered by the memory one cycle after mem_ren.

Function
REQ-003 SHALL implement FSM states IDLE, CMD and RESP.
REQ-004 IDLE: on psel=1 && penable=0, SHALL latch paddr, pwrite and pwdata, and go to CMD; otherwise SHALL stay in IDLE.
REQ-005 CMD: SHALL drive pready=0 and assert exactly one of mem_wen (write) or mem_ren (read) for this single cycle, unless the address is in error; then SHALL go to RESP.
REQ-006 RESP: SHALL drive pready=1; prdata=mem_rdata for a good read, otherwise 0; then SHALL go to IDLE.
REQ-007 Latency SHALL be fixed: setup cycle + CMD (wait state) + RESP, i.e. one wait state per transfer.
REQ-008 mem_addr SHALL equal latched paddr[3:0], and mem_wdata SHALL equal latched pwdata, both held stable from CMD through RESP.
REQ-009 mem_wen and mem_ren SHALL be registered outputs, high for exactly one cycle per transfer, never both high, and separated by at least two low cycles, which re-arms the memory's write-edge detect.
REQ-010 Back-to-back: a setup phase in the cycle after RESP SHALL be accepted in IDLE with no extra idle cycle.
REQ-011 If psel drops while in CMD or RESP, the FSM SHALL return to IDLE next cycle with pready=0 and pslverr=0; a memory strobe already issued is not retracted.
REQ-012 penable=1 seen while in IDLE without a preceding setup SHALL be ignored.
REQ-013 pslverr SHALL be asserted only when pready=1.

Reset
REQ-014 When rst_n=0 at a pclk edge, the block SHALL enter IDLE and clear all latched fields to 0.
REQ-015 Reset values SHALL be: pready=0, pslverr=0, prdata=0, mem_wen=0, mem_ren=0, mem_addr=0, mem_wdata=0.
REQ-016 Reset asserted mid-transfer SHALL abort the transfer with no pready pulse; a strobe issued in that same cycle SHALL be suppressed.

Configuration
REQ-017 SHALL support macro APB_ADDR_ERR_EN.
REQ-018 With APB_ADDR_ERR_EN defined, a transfer with paddr[7:4]!=0 SHALL issue no memory strobe and SHALL complete in RESP with pslverr=1 and prdata=0.
REQ-019 Without APB_ADDR_ERR_EN, pslverr SHALL be tied 0, paddr[7:4] SHALL be ignored, and addresses SHALL alias modulo 16.

Structure
REQ-020 Package apb_pkg SHALL hold the FSM state enum and the constants APB_AW=8, MEM_AW=4 and DW=8.
REQ-021 The block SHALL be a single module with no sub-module; the subsystem top instantiates it next to the memory.

Verification
REQ-022 Write paddr=0x05, pwdata=0xA5 -> mem_wen high for one cycle with mem_addr=5 and mem_wdata=0xA5; pready high 2 cycles after setup; pslverr=0.
REQ-023 Read paddr=0x05 after REQ-022 -> mem_ren pulse in CMD; prdata=0xA5 when pready=1.
REQ-024 Back-to-back writes 0x01←0x11 then 0x02←0x22, followed by reads of both -> two separate mem_wen pulses; read data 0x11 and 0x22.
REQ-025 With APB_ADDR_ERR_EN, write paddr=0x25 -> no mem_wen pulse, pslverr=1 with pready, and a read of 0x05 still returns 0xA5; without the macro, the same write lands at address 5.
REQ-026 rst_n=0 during CMD of a read -> no pready pulse, all outputs 0 next cycle, and the FSM accepts a new setup after release.
REQ-027 psel dropped during CMD -> FSM returns to IDLE with no pready pulse.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB-to-SRAM slave controller.
package apb_pkg;

  localparam int APB_AW = 8;
  localparam int MEM_AW = 4;
  localparam int DW     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when the APB address reaches beyond the memory window.
  function automatic logic addr_hi_err(input logic [APB_AW-1:0] addr);
    return |addr[APB_AW-1:MEM_AW];
  endfunction

endpackage

// File: rtl/apb_slave_ctrl.sv
// APB slave fronting a 16x8 memory with one fixed wait state per transfer.
// Build option APB_ADDR_ERR_EN: out-of-window addresses complete with pslverr.
module apb_slave_ctrl
  import apb_pkg::*;
(
  input  logic                pclk,
  input  logic                rst_n,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [APB_AW-1:0]   paddr,
  input  logic [DW-1:0]       pwdata,
  output logic [DW-1:0]       prdata,
  output logic                pready,
  output logic                pslverr,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic                mem_wen,
  output logic                mem_ren,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata
);

  state_t            r_state;
  logic [MEM_AW-1:0] r_addr;
  logic [DW-1:0]     r_wdata;
  logic              r_write;
  logic              r_err;
  logic              r_wen;
  logic              r_ren;
  logic              r_pready;
  logic              r_pslverr;
  logic              r_rd_ok;
  logic              w_err;

`ifdef APB_ADDR_ERR_EN
  assign w_err = addr_hi_err(paddr);
`else
  logic w_unused_hi;
  assign w_unused_hi = ^paddr[APB_AW-1:MEM_AW];
  assign w_err       = 1'b0;
`endif

  // Strobes and handshake are registered one state ahead so they line up
  // exactly with the CMD and RESP cycles.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_wen     <= 1'b0;
      r_ren     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_rd_ok   <= 1'b0;
    end else begin
      r_wen     <= 1'b0;
      r_ren     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_rd_ok   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (psel && !penable) begin
            r_addr  <= paddr[MEM_AW-1:0];
            r_wdata <= pwdata;
            r_write <= pwrite;
            r_err   <= w_err;
            r_wen   <= pwrite && !w_err;
            r_ren   <= !pwrite && !w_err;
            r_state <= CMD;
          end
        end
        CMD: begin
          // A dropped psel abandons the transfer; the strobe already went out.
          if (!psel) begin
            r_state <= IDLE;
          end else begin
            r_pready  <= 1'b1;
            r_pslverr <= r_err;
            r_rd_ok   <= !r_write && !r_err;
            r_state   <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory returns read data in the RESP cycle, so it is steered straight through.
  assign prdata    = r_rd_ok ? mem_rdata : '0;
  assign pready    = r_pready;
  assign pslverr   = r_pslverr;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wen   = r_wen;
  assign mem_ren   = r_ren;

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Directed bench for apb_slave_ctrl with a behavioural 16x8 memory model.
module tb_apb_slave_ctrl;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = 8'h00;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic [3:0] mem_addr;
  logic       mem_wen;
  logic       mem_ren;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [16];

  int n_chk = 0;
  int n_err = 0;
  int gap = 10;
  int viol_gap = 0;
  int viol_both = 0;
  int viol_slverr = 0;
  int viol_prdata = 0;

  apb_slave_ctrl dut (
    .pclk(pclk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= mem[mem_addr];
  end

  // Protocol watchers: strobe spacing, exclusivity, error/data qualification.
  always @(negedge pclk) begin
    if (mem_wen || mem_ren) begin
      if (gap < 2) viol_gap <= viol_gap + 1;
      gap <= 0;
    end else begin
      gap <= gap + 1;
    end
    if (mem_wen && mem_ren) viol_both <= viol_both + 1;
    if (pslverr && !pready) viol_slverr <= viol_slverr + 1;
    if (!pready && prdata != 8'h00) viol_prdata <= viol_prdata + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic err, output int nw,
                          output int nr, output logic [7:0] sa, output logic [7:0] sd,
                          output int lat);
    nw = 0; nr = 0; rd = 8'h00; err = 1'b0; sa = 8'h00; sd = 8'h00; lat = 99;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge pclk);
      if (mem_wen) begin nw++; sa = {4'h0, mem_addr}; sd = mem_wdata; end
      if (mem_ren) begin nr++; sa = {4'h0, mem_addr}; end
      if (pready) begin lat = c; rd = prdata; err = pslverr; end
      @(posedge pclk); #1;
      if (lat != 99) break;
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk_eq({tag, "_pready"}, pready, 0);
    chk_eq({tag, "_pslverr"}, pslverr, 0);
    chk_eq({tag, "_prdata"}, prdata, 0);
    chk_eq({tag, "_wen"}, mem_wen, 0);
    chk_eq({tag, "_ren"}, mem_ren, 0);
    chk_eq({tag, "_addr"}, mem_addr, 0);
    chk_eq({tag, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    logic [7:0] rd, sa, sd;
    logic       err;
    int         nw, nr, lat, rdy;

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_outputs_zero("rst");
    @(posedge pclk); #1;
    rst_n = 1'b1;
    @(posedge pclk); #1;

    // Single write then read-back.
    apb_xfer(1'b1, 8'h05, 8'hA5, rd, err, nw, nr, sa, sd, lat);
    chk_eq("wr05_wen", nw, 1);
    chk_eq("wr05_ren", nr, 0);
    chk_eq("wr05_addr", sa, 8'h05);
    chk_eq("wr05_wdata", sd, 8'hA5);
    chk_eq("wr05_lat", lat, 2);
    chk_eq("wr05_err", err, 0);
    apb_xfer(1'b0, 8'h05, 8'h00, rd, err, nw, nr, sa, sd, lat);
    chk_eq("rd05_ren", nr, 1);
    chk_eq("rd05_wen", nw, 0);
    chk_eq("rd05_addr", sa, 8'h05);
    chk_eq("rd05_data", rd, 8'hA5);
    chk_eq("rd05_lat", lat, 2);

    // penable without setup must be ignored.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'hFF;
    nw = 0; rdy = 0;
    repeat (3) begin
      @(negedge pclk);
      if (mem_wen || mem_ren) nw++;
      if (pready) rdy++;
      @(posedge pclk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    chk_eq("noset_strobe", nw, 0);
    chk_eq("noset_pready", rdy, 0);

    // Back-to-back writes and reads.
    apb_xfer(1'b1, 8'h01, 8'h11, rd, err, nw, nr, sa, sd, lat);
    chk_eq("b2b_w1_wen", nw, 1);
    apb_xfer(1'b1, 8'h02, 8'h22, rd, err, nw, nr, sa, sd, lat);
    chk_eq("b2b_w2_wen", nw, 1);
    chk_eq("b2b_w2_addr", sa, 8'h02);
    chk_eq("b2b_w2_lat", lat, 2);
    apb_xfer(1'b0, 8'h01, 8'h00, rd, err, nw, nr, sa, sd, lat);
    chk_eq("b2b_r1_data", rd, 8'h11);
    apb_xfer(1'b0, 8'h02, 8'h00, rd, err, nw, nr, sa, sd, lat);
    chk_eq("b2b_r2_data", rd, 8'h22);
    apb_xfer(1'b0, 8'h05, 8'h00, rd, err, nw, nr, sa, sd, lat);
    chk_eq("noset_keep05", rd, 8'hA5);

    // Out-of-window address.
    apb_xfer(1'b1, 8'h25, 8'h5A, rd, err, nw, nr, sa, sd, lat);
`ifdef APB_ADDR_ERR_EN
    chk_eq("err25_wen", nw, 0);
    chk_eq("err25_slverr", err, 1);
    chk_eq("err25_lat", lat, 2);
    apb_xfer(1'b0, 8'h05, 8'h00, rd, err, nw, nr, sa, sd, lat);
    chk_eq("err25_rd05", rd, 8'hA5);
    apb_xfer(1'b0, 8'h35, 8'h00, rd, err, nw, nr, sa, sd, lat);
    chk_eq("err35_ren", nr, 0);
    chk_eq("err35_slverr", err, 1);
    chk_eq("err35_prdata", rd, 8'h00);
`else
    chk_eq("alias25_wen", nw, 1);
    chk_eq("alias25_addr", sa, 8'h05);
    chk_eq("alias25_slverr", err, 0);
    apb_xfer(1'b0, 8'h05, 8'h00, rd, err, nw, nr, sa, sd, lat);
    chk_eq("alias25_rd05", rd, 8'h5A);
    apb_xfer(1'b0, 8'hF1, 8'h00, rd, err, nw, nr, sa, sd, lat);
    chk_eq("aliasF1_rd", rd, 8'h11);
    chk_eq("aliasF1_slverr", err, 0);
`endif

    // Reset asserted during CMD of a read.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h01;
    @(posedge pclk); #1;
    penable = 1'b1; rst_n = 1'b0;
    @(negedge pclk);
    chk_eq("rstcmd_pready_cmd", pready, 0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check_outputs_zero("rstcmd");
    @(posedge pclk); #1;
    rst_n = 1'b1;
    rdy = 0;
    repeat (2) begin
      @(negedge pclk);
      if (pready) rdy++;
      @(posedge pclk); #1;
    end
    chk_eq("rstcmd_nopready", rdy, 0);
    apb_xfer(1'b0, 8'h02, 8'h00, rd, err, nw, nr, sa, sd, lat);
    chk_eq("rstcmd_after_data", rd, 8'h22);
    chk_eq("rstcmd_after_lat", lat, 2);

    // psel dropped during CMD.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 8'h33;
    @(posedge pclk); #1;
    psel = 1'b0;
    nw = 0; rdy = 0;
    repeat (3) begin
      @(negedge pclk);
      if (mem_wen) nw++;
      if (pready) rdy++;
      @(posedge pclk); #1;
    end
    chk_eq("drop_wen", nw, 1);
    chk_eq("drop_pready", rdy, 0);
    apb_xfer(1'b0, 8'h03, 8'h00, rd, err, nw, nr, sa, sd, lat);
    chk_eq("drop_rd03", rd, 8'h33);
    chk_eq("drop_lat", lat, 2);

    @(posedge pclk); #1;
    chk_eq("strobe_gap", viol_gap, 0);
    chk_eq("strobe_both", viol_both, 0);
    chk_eq("slverr_qual", viol_slverr, 0);
    chk_eq("prdata_qual", viol_prdata, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

endmodule
